// File: rtl/photon_pkg.sv
// Shared types and widths for the photon time-of-flight acquisition sequencer.
package photon_pkg;

    localparam int TIMER_W_DEF = 16;
    localparam int SHOT_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_ARM,
        S_RESULT,
        S_GAP
    } state_t;

endpackage

// File: rtl/pmt_edge_sync.sv
// Brings the asynchronous active-low PMT stop into the clk domain and emits a
// registered one-cycle pulse per falling edge (3 cycles pin-to-pulse).
module pmt_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic stop_n,
    output logic stop_ev
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
            stop_ev <= 1'b0;
        end else begin
            // sync_p0/p1 form the metastability chain, sync_p2 is the edge history
            sync_p0 <= stop_n;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            stop_ev <= sync_p2 & ~sync_p1;
        end
    end

endmodule

// File: rtl/photon_acq_sequencer.sv
// Laser-fire / PMT-capture sequencer: fires a burst of shots, times the first
// stop event of each shot within a detection window, and hands out one result per shot.
module photon_acq_sequencer
    import photon_pkg::*;
#(
    parameter int TIMER_W  = TIMER_W_DEF,
    parameter int PERIOD   = 1000,
    parameter int WINDOW   = 500,
    parameter int TRIG_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [SHOT_W-1:0]  num_shots,
    input  logic               stop_n,
    output logic               laser_trig,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [TIMER_W-1:0] res_time,
    output logic               res_hit,
    output logic [SHOT_W-1:0]  res_shot
);

    localparam logic [TIMER_W-1:0] FIRE_LAST = TIMER_W'(TRIG_LEN - 1);
    localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(WINDOW - 1);
    localparam logic [TIMER_W-1:0] PER_LAST  = TIMER_W'(PERIOD - 1);

    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, per_q, res_time_q;
    logic [SHOT_W-1:0]   shot_q, last_q;
    logic                hit_pend_q, done_q, res_hit_q;
    logic                stop_ev;
    logic                cap_hit, cap_miss, hs, finish, accept, enter_fire;

    pmt_edge_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .stop_n  (stop_n),
        .stop_ev (stop_ev)
    );

    always_comb begin
        state_d    = state_q;
        cap_hit    = 1'b0;
        cap_miss   = 1'b0;
        hs         = 1'b0;
        finish     = 1'b0;
        laser_trig = (state_q == S_FIRE);
        busy       = (state_q != S_IDLE);
        res_valid  = (state_q == S_RESULT);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FIRE;
            end
            S_FIRE: begin
                // An early hit is latched but the laser pulse still runs its full length
                if (stop_ev && !hit_pend_q) cap_hit = 1'b1;
                if (timer_q == FIRE_LAST)
                    state_d = (hit_pend_q || cap_hit) ? S_RESULT : S_ARM;
            end
            S_ARM: begin
                if (stop_ev) begin
                    cap_hit = 1'b1;
                    state_d = S_RESULT;
                end else if (timer_q == WIN_LAST) begin
                    cap_miss = 1'b1;
                    state_d  = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    hs = 1'b1;
                    if (shot_q == last_q) begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // >= also covers a period already overrun by a stalled consumer
                if (per_q >= PER_LAST) state_d = S_FIRE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            cap_hit  = 1'b0;
            cap_miss = 1'b0;
            hs       = 1'b0;
            finish   = 1'b0;
        end
    end

    assign accept     = (state_q == S_IDLE) && (state_d == S_FIRE);
    assign enter_fire = (state_q != S_FIRE) && (state_d == S_FIRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            per_q      <= '0;
            shot_q     <= '0;
            last_q     <= '0;
            hit_pend_q <= 1'b0;
            done_q     <= 1'b0;
            res_time_q <= '0;
            res_hit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            // num_shots of 0 wraps to a last index of 255, i.e. 256 shots
            if (accept) begin
                shot_q <= '0;
                last_q <= num_shots - 1'b1;
            end else if (hs && !finish) begin
                shot_q <= shot_q + 1'b1;
            end
            if (enter_fire) begin
                timer_q    <= '0;
                per_q      <= '0;
                hit_pend_q <= 1'b0;
            end else begin
                per_q <= sat_inc(per_q);
                if (state_q == S_FIRE || state_q == S_ARM) timer_q <= sat_inc(timer_q);
            end
            if (cap_hit) begin
                res_time_q <= timer_q;
                res_hit_q  <= 1'b1;
                hit_pend_q <= 1'b1;
            end else if (cap_miss) begin
                res_time_q <= '0;
                res_hit_q  <= 1'b0;
            end
        end
    end

    assign done     = done_q;
    assign res_time = res_time_q;
    assign res_hit  = res_hit_q;
    assign res_shot = shot_q;

endmodule

// File: tb/tb_photon_acq_sequencer.sv
// Directed bench for photon_acq_sequencer with PERIOD=100, WINDOW=50, TRIG_LEN=4.
module tb_photon_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_shots = 8'd0;
    logic        stop_n = 1'b1;
    logic        res_ready = 1'b1;
    logic        laser_trig, busy, done, res_valid, res_hit;
    logic [15:0] res_time;
    logic [7:0]  res_shot;

    int cyc = 0;
    int total = 0;
    int fails = 0;
    int t0, tk, dev;

    photon_acq_sequencer #(
        .TIMER_W  (16),
        .PERIOD   (100),
        .WINDOW   (50),
        .TRIG_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_shots  (num_shots),
        .stop_n     (stop_n),
        .laser_trig (laser_trig),
        .busy       (busy),
        .done       (done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_time   (res_time),
        .res_hit    (res_hit),
        .res_shot   (res_shot)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_laser(input int lim, input string tag);
        int n = 0;
        while (laser_trig !== 1'b1 && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, laser_trig, 1);
    endtask

    task automatic wait_valid(input int lim, input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, res_valid, 1);
    endtask

    initial begin
        // reset state
        step(3);
        chk("rst_laser", laser_trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_hit", res_hit, 0);
        chk("rst_time", res_time, 0);
        chk("rst_shot", res_shot, 0);
        rst = 1'b0;
        step(2);

        // single shot, stop 20 cycles after trigger rise
        num_shots = 8'd1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t1_laser_rise", laser_trig, 1);
        chk("t1_busy", busy, 1);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 3) chk("t1_laser_c3", laser_trig, 1);
            if (i == 4) chk("t1_laser_c4", laser_trig, 0);
        end
        stop_n = 1'b0;
        step(3);
        chk("t1_valid_early", res_valid, 0);
        step(1);
        chk("t1_valid", res_valid, 1);
        chk("t1_time", res_time, 23);
        chk("t1_hit", res_hit, 1);
        chk("t1_shot", res_shot, 0);
        chk("t1_done_before", done, 0);
        step(1);
        chk("t1_done", done, 1);
        chk("t1_valid_drop", res_valid, 0);
        chk("t1_busy_end", busy, 0);
        step(1);
        chk("t1_done_pulse", done, 0);
        stop_n = 1'b1;
        step(5);

        // three shots, no stop: misses at 100-cycle spacing
        num_shots = 8'd3;
        start = 1'b1;
        step(1);
        start = 1'b0;
        t0 = cyc;
        chk("t2_laser0", laser_trig, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_laser(300, "t2_laser_to");
                chk("t2_rise_cyc", cyc - t0, 100 * k);
            end
            tk = cyc;
            wait_valid(200, "t2_valid_to");
            chk("t2_res_lat", cyc - tk, 50);
            chk("t2_hit", res_hit, 0);
            chk("t2_time", res_time, 0);
            chk("t2_shot", res_shot, k);
            step(1);
            chk("t2_done", done, (k == 2) ? 1 : 0);
        end
        chk("t2_busy_end", busy, 0);
        step(3);

        // window boundary: event at timer 49 hits, at 50 misses
        num_shots = 8'd1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(46);
        stop_n = 1'b0;
        wait_valid(100, "t3a_valid_to");
        chk("t3a_time", res_time, 49);
        chk("t3a_hit", res_hit, 1);
        step(1);
        stop_n = 1'b1;
        step(5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        t0 = cyc;
        step(47);
        stop_n = 1'b0;
        wait_valid(100, "t3b_valid_to");
        chk("t3b_lat", cyc - t0, 50);
        chk("t3b_time", res_time, 0);
        chk("t3b_hit", res_hit, 0);
        step(1);
        chk("t3b_done", done, 1);
        stop_n = 1'b1;
        step(5);

        // stalled consumer
        num_shots = 8'd2;
        res_ready = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(100, "t4_valid_to");
        dev = 0;
        repeat (150) begin
            step(1);
            if (res_valid !== 1'b1 || res_time !== 16'd0 || res_hit !== 1'b0 ||
                res_shot !== 8'd0 || laser_trig !== 1'b0) dev++;
        end
        chk("t4_stable", dev, 0);
        res_ready = 1'b1;
        step(1);
        chk("t4_gap_valid", res_valid, 0);
        chk("t4_gap_laser", laser_trig, 0);
        chk("t4_gap_busy", busy, 1);
        step(1);
        chk("t4_refire", laser_trig, 1);
        wait_valid(100, "t4_valid2_to");
        chk("t4_shot1", res_shot, 1);
        step(1);
        chk("t4_done", done, 1);
        step(3);

        // abort during ARM of third shot
        num_shots = 8'd4;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(100, "t5_v0_to");
        step(1);
        wait_laser(300, "t5_l1_to");
        wait_valid(100, "t5_v1_to");
        step(1);
        wait_laser(300, "t5_l2_to");
        step(10);
        chk("t5_armed_busy", busy, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_valid", res_valid, 0);
        chk("t5_done", done, 0);
        dev = 0;
        repeat (300) begin
            step(1);
            if (laser_trig !== 1'b0 || done !== 1'b0 || busy !== 1'b0) dev++;
        end
        chk("t5_quiet", dev, 0);

        // start coincident with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_laser", laser_trig, 0);
        step(2);

        // reset during RESULT, then a clean burst
        num_shots = 8'd2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_valid(100, "t7_v0_to");
        step(1);
        res_ready = 1'b0;
        wait_laser(300, "t7_l1_to");
        step(10);
        stop_n = 1'b0;
        wait_valid(100, "t7_v1_to");
        chk("t7_time", res_time, 13);
        chk("t7_hit", res_hit, 1);
        chk("t7_shot", res_shot, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_valid", res_valid, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_time", res_time, 0);
        chk("t7_rst_hit", res_hit, 0);
        chk("t7_rst_shot", res_shot, 0);
        chk("t7_rst_laser", laser_trig, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stop_n = 1'b1;
        dev = 0;
        repeat (5) begin
            step(1);
            if (done !== 1'b0 || busy !== 1'b0) dev++;
        end
        chk("t7_no_done", dev, 0);
        res_ready = 1'b1;
        num_shots = 8'd1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(20);
        stop_n = 1'b0;
        step(4);
        chk("t7_clean_valid", res_valid, 1);
        chk("t7_clean_time", res_time, 23);
        chk("t7_clean_shot", res_shot, 0);
        step(1);
        chk("t7_clean_done", done, 1);
        stop_n = 1'b1;
        step(3);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
